ysyx_24110015_alu_arbiter: RTL and testbench
============================================

# ysyx_24110015_alu_arbiter

Shares the single 32-bit combinational ALU (ysyx_24110015_ALU, instantiated inside this block) between two requesters, the EXU (port 0) and the LSU address path (port 1). Each port presents operands and a 4-bit ALU opcode over a valid/ready handshake. A round-robin arbiter selects one request per cycle, registers the ALU result and returns it on the winning port's response channel. The response is tagged so only the granted port sees rsp_valid.

## Interface
- DATA_WIDTH, 32, operand/result width; passed to the ALU instance
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  request present on port 0 / 1
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_op / req1_op  in  4  ALU opcode (`ALU_* encodings from macros.v), forwarded unchanged to ALUop
- req0_a, req0_b / req1_a, req1_b  in  DATA_WIDTH  operands, forwarded to data1/data2
- rsp0_valid / rsp1_valid  out  1  result available for port 0 / 1
- rsp0_ready / rsp1_ready  in  1  port consumes result
- rsp_data  out  DATA_WIDTH  registered ALU result, shared by both response ports
- busy  out  1  result register holds an unconsumed result

## Operation
- State: IDLE (result register empty) and HOLD (result register full; owner tag = 0 or 1).
- Round-robin pointer `last` (1 bit) names the most recently granted port; reset value 1, so port 0 wins the first tie.
- Grant: if exactly one reqN_valid, grant N; if both, grant !last; if none, no grant.
- ALU inputs are muxed from the granted port; with no grant they come from port 0. No other operand or opcode modification.
- can_accept = (state == IDLE) | (state == HOLD & rspT_ready for owner T).
- reqN_ready = can_accept & grant == N. The non-granted port always sees ready = 0. Ready depends combinationally on valid and rsp_ready; no combinational path from ready to valid.
- Acceptance (reqN_valid & reqN_ready) at edge: rsp_data <= ALUout, owner <= N, last <= N, state <= HOLD.
- HOLD with owner consuming and no new acceptance: state <= IDLE; rsp_data keeps its old value.
- rspN_valid = (state == HOLD) & owner == N. busy = (state == HOLD).
- Reserved opcodes 4'b1110/4'b1111 produce result 0 and are otherwise handled normally.
- Reset (any time, including in HOLD): state IDLE, owner 0, last 1, rsp_data 0. All outputs low except rsp_data = 0. A pending result is discarded and is not replayed.

## Timing
- Latency: request accepted at edge N, result on rsp_data with rspX_valid high from N+1.
- Throughput: 1 result/cycle when the owner asserts rsp_ready continuously. Back-to-back accept and consume happen in the same cycle.
- Owner stalls (rsp_ready = 0): rsp_data and rspX_valid hold stable. Both req_ready stay 0 until consumed.
- Requester must hold valid/op/a/b stable until ready. Arbitration may re-evaluate each cycle, but `last` updates only on acceptance, so a waiting port wins next if the other was just served.
- Response to the owner and a new grant to the other port in the same cycle is legal. The owner tag switches at that edge.
- No X propagation: with no grant, ALU inputs come from port 0 and the result is not captured.

## Test plan
- Reset: assert reset mid-HOLD -> immediately busy = 0, rsp0/1_valid = 0, rsp_data = 0. After release, both valid with `ALU_SUB, a = 10, b = 3 -> port 0 granted, rsp0_valid next cycle, rsp_data = 7.
- Single port: port 1 `ALU_XOR 0xFF00FF00 ^ 0x0F0F0F0F`, rsp1_ready = 1 -> rsp_data = 0xF00FF00F one cycle later. rsp0_valid stays 0.
- Fairness: both ports valid continuously for 6 cycles, both rsp_ready = 1 -> grants alternate 0,1,0,1,0,1, one result per cycle, no port starved.
- Backpressure: port 0 `ALU_SLL 1 << 5`, rsp0_ready = 0 for 3 cycles -> rsp_data = 32 held, req0/1_ready = 0. Release -> same-cycle accept of a pending port 1 request.
- Signed/unsigned compare: `ALU_LT 0xFFFFFFFF vs 1` -> 1; `ALU_LTU` same operands -> 0; `ALU_SRA 0x80000000 >> 4` -> 0xF8000000.
- Reserved opcode: op 4'b1111 with a = b = 0xFFFFFFFF -> rsp_data = 0, handshake completes normally.

Source files
------------

// File: rtl/ysyx_24110015_alu_arbiter.sv
// rtl/ysyx_24110015_alu_arbiter.sv - two-port round-robin arbiter sharing one combinational ALU

module ysyx_24110015_ALU #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] data1,
    input  logic [DATA_WIDTH-1:0] data2,
    input  logic [3:0]            ALUop,
    output logic [DATA_WIDTH-1:0] ALUout
);
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_LT   = 4'd3;
    localparam logic [3:0] ALU_LTU  = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_EQ   = 4'd10;
    localparam logic [3:0] ALU_NE   = 4'd11;
    localparam logic [3:0] ALU_GE   = 4'd12;
    localparam logic [3:0] ALU_GEU  = 4'd13;
    localparam int SW = $clog2(DATA_WIDTH);

    logic [SW-1:0] shamt;
    logic          flag;

    always_comb begin
        shamt  = data2[SW-1:0];
        flag   = 1'b0;
        ALUout = '0;
        case (ALUop)
            ALU_ADD: ALUout = data1 + data2;
            ALU_SUB: ALUout = data1 - data2;
            ALU_SLL: ALUout = data1 << shamt;
            ALU_XOR: ALUout = data1 ^ data2;
            ALU_SRL: ALUout = data1 >> shamt;
            ALU_SRA: ALUout = $signed(data1) >>> shamt;
            ALU_OR:  ALUout = data1 | data2;
            ALU_AND: ALUout = data1 & data2;
            ALU_LT:  flag = $signed(data1) < $signed(data2);
            ALU_LTU: flag = data1 < data2;
            ALU_EQ:  flag = data1 == data2;
            ALU_NE:  flag = data1 != data2;
            ALU_GE:  flag = $signed(data1) >= $signed(data2);
            ALU_GEU: flag = data1 >= data2;
            default: ALUout = '0;
        endcase
        // Compare results are zero-extended single bits
        if (ALUop inside {ALU_LT, ALU_LTU, ALU_EQ, ALU_NE, ALU_GE, ALU_GEU})
            ALUout = {{(DATA_WIDTH-1){1'b0}}, flag};
    end
endmodule

module ysyx_24110015_alu_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [3:0]            req0_op,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [3:0]            req1_op,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  busy
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t                state;
    logic                  owner;
    logic                  last;
    logic                  grant;
    logic                  owner_ready;
    logic                  can_accept;
    logic                  accept;
    logic [3:0]            alu_op;
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [DATA_WIDTH-1:0] alu_out;

    always_comb begin
        // With no request grant stays 0, so the ALU sees port 0 operands
        grant       = (req0_valid & req1_valid) ? ~last : req1_valid;
        owner_ready = owner ? rsp1_ready : rsp0_ready;
        can_accept  = ~reset & ((state == IDLE) | owner_ready);
        req0_ready  = can_accept & req0_valid & ~grant;
        req1_ready  = can_accept & req1_valid & grant;
        accept      = req0_ready | req1_ready;
        alu_op      = grant ? req1_op : req0_op;
        alu_a       = grant ? req1_a  : req0_a;
        alu_b       = grant ? req1_b  : req0_b;
    end

    ysyx_24110015_ALU #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .data1  (alu_a),
        .data2  (alu_b),
        .ALUop  (alu_op),
        .ALUout (alu_out)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= 1'b0;
            last     <= 1'b1;
            rsp_data <= '0;
        end else if (accept) begin
            state    <= HOLD;
            owner    <= grant;
            last     <= grant;
            rsp_data <= alu_out;
        end else if (state == HOLD && owner_ready) begin
            state    <= IDLE;
        end
    end

    assign busy       = (state == HOLD);
    assign rsp0_valid = busy & ~owner;
    assign rsp1_valid = busy & owner;
endmodule

// File: tb/tb_ysyx_24110015_alu_arbiter.sv
// tb/tb_ysyx_24110015_alu_arbiter.sv - self-checking bench for ysyx_24110015_alu_arbiter

module tb_ysyx_24110015_alu_arbiter;
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLL = 4'd2, OP_LT = 4'd3,
                           OP_LTU = 4'd4, OP_XOR = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                           OP_OR = 4'd8, OP_AND = 4'd9, OP_EQ = 4'd10, OP_NE = 4'd11,
                           OP_GE = 4'd12, OP_GEU = 4'd13;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
    logic [3:0]  req0_op = 0, req1_op = 0;
    logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
    logic [31:0] rsp_data;

    int n_tests = 0;
    int n_fail  = 0;

    ysyx_24110015_alu_arbiter #(.DATA_WIDTH(32)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD: return a + b;
            OP_SUB: return a - b;
            OP_SLL: return a << b[4:0];
            OP_LT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_LTU: return (a < b) ? 32'd1 : 32'd0;
            OP_XOR: return a ^ b;
            OP_SRL: return a >> b[4:0];
            OP_SRA: return 32'($signed(a) >>> b[4:0]);
            OP_OR:  return a | b;
            OP_AND: return a & b;
            OP_EQ:  return (a == b) ? 32'd1 : 32'd0;
            OP_NE:  return (a != b) ? 32'd1 : 32'd0;
            OP_GE:  return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
            OP_GEU: return (a >= b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
        end
    endtask

    // Transaction-level model: a one-entry result slot plus the last-served port
    logic        m_full = 0, m_owner = 0, m_last = 1;
    logic [31:0] m_data = 0;

    always @(negedge clock) begin
        logic who, consumes, can;
        if (reset) begin
            check("rst_busy", {31'd0, busy}, 0);
            check("rst_rsp0", {31'd0, rsp0_valid}, 0);
            check("rst_rsp1", {31'd0, rsp1_valid}, 0);
            check("rst_rdy",  {30'd0, req0_ready, req1_ready}, 0);
            check("rst_data", rsp_data, 0);
            m_full = 0; m_owner = 0; m_last = 1; m_data = 0;
        end else begin
            if (req0_valid && req1_valid) who = !m_last;
            else                          who = req1_valid;
            consumes = m_full && (m_owner ? rsp1_ready : rsp0_ready);
            can      = !m_full || consumes;
            check("m_busy", {31'd0, busy}, {31'd0, m_full});
            check("m_rsp0", {31'd0, rsp0_valid}, {31'd0, m_full && !m_owner});
            check("m_rsp1", {31'd0, rsp1_valid}, {31'd0, m_full && m_owner});
            check("m_data", rsp_data, m_data);
            check("m_rdy0", {31'd0, req0_ready}, {31'd0, can && req0_valid && !who});
            check("m_rdy1", {31'd0, req1_ready}, {31'd0, can && req1_valid && who});
            if (can && (req0_valid || req1_valid)) begin
                m_full  = 1;
                m_owner = who;
                m_last  = who;
                m_data  = who ? alu_ref(req1_op, req1_a, req1_b) : alu_ref(req0_op, req0_a, req0_b);
            end else if (consumes) begin
                m_full = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        tick(); tick();
        reset = 0;
        tick();

        // Single port 1 XOR
        req1_valid = 1; req1_op = OP_XOR; req1_a = 32'hFF00FF00; req1_b = 32'h0F0F0F0F; rsp1_ready = 1;
        tick();
        req1_valid = 0;
        check("xor_data", rsp_data, 32'hF00FF00F);
        check("xor_rsp1", {31'd0, rsp1_valid}, 1);
        check("xor_rsp0", {31'd0, rsp0_valid}, 0);
        tick();
        check("xor_idle", {31'd0, busy}, 0);

        // Reset while holding a stalled result
        req0_valid = 1; req0_op = OP_SLL; req0_a = 1; req0_b = 5; rsp0_ready = 0;
        tick();
        check("hold_busy", {31'd0, busy}, 1);
        reset = 1; req0_valid = 0;
        #1;
        check("rst_now_busy", {31'd0, busy}, 0);
        check("rst_now_rsp0", {31'd0, rsp0_valid}, 0);
        check("rst_now_data", rsp_data, 0);
        tick();
        reset = 0;
        req0_valid = 1; req0_op = OP_SUB; req0_a = 10; req0_b = 3;
        req1_valid = 1; req1_op = OP_SUB; req1_a = 10; req1_b = 3;
        rsp0_ready = 1; rsp1_ready = 0;
        tick();
        check("tie_rsp0", {31'd0, rsp0_valid}, 1);
        check("tie_data", rsp_data, 7);
        req0_valid = 0;
        tick();
        req1_valid = 0; rsp1_ready = 1;
        tick();

        // Fairness: alternating grants with both ports always valid
        req0_valid = 1; req0_op = OP_ADD; req0_a = 1;   req0_b = 2;
        req1_valid = 1; req1_op = OP_SUB; req1_a = 100; req1_b = 1;
        rsp0_ready = 1; rsp1_ready = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rr_rsp0", {31'd0, rsp0_valid}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_data", rsp_data, (i % 2 == 0) ? 32'd3 : 32'd99);
        end
        req0_valid = 0; req1_valid = 0;
        tick();

        // Backpressure on port 0, port 1 pending
        req0_valid = 1; req0_op = OP_SLL; req0_a = 1; req0_b = 5; rsp0_ready = 0;
        tick();
        req0_valid = 0;
        req1_valid = 1; req1_op = OP_OR; req1_a = 32'h0000F000; req1_b = 32'h0000000F;
        for (int i = 0; i < 3; i++) begin
            check("bp_data", rsp_data, 32);
            check("bp_rdy", {30'd0, req0_ready, req1_ready}, 0);
            tick();
        end
        rsp0_ready = 1;
        #1;
        check("bp_release_rdy1", {31'd0, req1_ready}, 1);
        tick();
        check("bp_rsp1", {31'd0, rsp1_valid}, 1);
        check("bp_or_data", rsp_data, 32'h0000F00F);
        req1_valid = 0;
        tick();

        // Signed/unsigned compare, arithmetic shift, reserved opcode
        req0_valid = 1; req0_op = OP_LT; req0_a = 32'hFFFFFFFF; req0_b = 1; rsp0_ready = 1;
        tick();
        check("lt", rsp_data, 1);
        req0_op = OP_LTU;
        tick();
        check("ltu", rsp_data, 0);
        req0_op = OP_SRA; req0_a = 32'h80000000; req0_b = 4;
        tick();
        check("sra", rsp_data, 32'hF8000000);
        req0_op = 4'b1111; req0_a = 32'hFFFFFFFF; req0_b = 32'hFFFFFFFF;
        tick();
        check("rsvd", rsp_data, 0);
        check("rsvd_rsp0", {31'd0, rsp0_valid}, 1);
        req0_valid = 0;
        tick();
        check("end_idle", {31'd0, busy}, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
